// File: rtl/shift_unit_pkg.sv
// Shared types for the iterative shift unit: op encodings, FSM states, default widths.
// No logic of its own; op_supported() decides which op codes are executable.
// Optional feature macro: SHIFT_ROTATE_EN (enables ROL/ROR as legal ops).
package shift_unit_pkg;

   localparam int DEF_DATA_WIDTH   = 32;
   localparam int DEF_AMOUNT_WIDTH = 5;

   typedef enum logic [2:0] {
      OP_NOP = 3'b000,
      OP_SLL = 3'b001,
      OP_SRL = 3'b010,
      OP_SRA = 3'b011,
      OP_ROL = 3'b100,
      OP_ROR = 3'b101
   } shift_op_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } state_t;

   // Rotates only count as supported when the rotate datapath is built.
   function automatic logic op_supported(input logic [2:0] op);
      logic ok;
      ok = 1'b0;
      case (op)
         OP_NOP, OP_SLL, OP_SRL, OP_SRA: ok = 1'b1;
`ifdef SHIFT_ROTATE_EN
         OP_ROL, OP_ROR:                 ok = 1'b1;
`endif
         default:                        ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/shift_step.sv
// One-bit shift/rotate step of the latched operand, purely combinational.
// Latency: 0 cycles (feeds the data register in the top).
// Backpressure: none; the top decides when the step is applied. Macro: SHIFT_ROTATE_EN.
module shift_step
   import shift_unit_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic [2:0]            op,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout
);

   // Select the single-position move for the latched op; unknown ops pass through.
   always_comb begin
      dout = din;
      case (op)
         OP_SLL:  dout = {din[DATA_WIDTH-2:0], 1'b0};
         OP_SRL:  dout = {1'b0, din[DATA_WIDTH-1:1]};
         OP_SRA:  dout = {din[DATA_WIDTH-1], din[DATA_WIDTH-1:1]};
`ifdef SHIFT_ROTATE_EN
         OP_ROL:  dout = {din[DATA_WIDTH-2:0], din[DATA_WIDTH-1]};
         OP_ROR:  dout = {din[0], din[DATA_WIDTH-1:1]};
`endif
         default: dout = din;
      endcase
   end

endmodule

// File: rtl/iterative_shift_unit.sv
// Multicycle shifter: one bit position per clock, start/done handshake with the control FSM.
// Latency: done in cycle N+1 after accept (cycle 1 for amount 0, NOP or illegal op); one op per N+2 cycles.
// Backpressure: start is only sampled in IDLE and ignored while busy. Macro: SHIFT_ROTATE_EN.
module iterative_shift_unit
   import shift_unit_pkg::*;
#(
   parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int AMOUNT_WIDTH = DEF_AMOUNT_WIDTH
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    start,
   input  logic [2:0]              shift_op,
   input  logic [DATA_WIDTH-1:0]   shift_data_in,
   input  logic [AMOUNT_WIDTH-1:0] shift_amount,
   output logic                    busy,
   output logic                    done,
   output logic [DATA_WIDTH-1:0]   shift_result,
   output logic                    illegal_op
);

   state_t                  state_q;
   state_t                  state_d;
   logic [2:0]              op_q;
   logic [DATA_WIDTH-1:0]   data_q;
   logic [DATA_WIDTH-1:0]   step_data;
   logic [AMOUNT_WIDTH-1:0] count_q;
   logic                    accept;
   logic                    op_ok;

   assign op_ok = op_supported(shift_op);

   shift_step #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_step (
      .op   (op_q),
      .din  (data_q),
      .dout (step_data)
   );

   // Next-state logic; zero-work requests skip SHIFT and go straight to DONE.
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               accept = 1'b1;
               if (!op_ok || (shift_op == OP_NOP) || (shift_amount == '0)) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_SHIFT;
               end
            end
         end
         ST_SHIFT: begin
            // count_q holds the steps still to apply including this one.
            if (count_q == AMOUNT_WIDTH'(1)) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State register; reset abandons any operation in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Operand/op/count capture on accept, then one step per SHIFT cycle; illegal flag is sticky.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         op_q       <= 3'b000;
         data_q     <= '0;
         count_q    <= '0;
         illegal_op <= 1'b0;
      end else if (accept) begin
         op_q    <= shift_op;
         data_q  <= shift_data_in;
         count_q <= shift_amount;
         if (!op_ok) begin
            illegal_op <= 1'b1;
         end
      end else if (state_q == ST_SHIFT) begin
         data_q  <= step_data;
         count_q <= count_q - AMOUNT_WIDTH'(1);
      end
   end

   assign busy         = (state_q != ST_IDLE);
   assign done         = (state_q == ST_DONE);
   assign shift_result = data_q;

endmodule
